// File: rtl/boton_evento_pkg.sv
// Shared definitions for the button event classifier.
//   boton_state_e : FSM state encoding (ARM=0, IDLE=1, PRESSED=2, HELD=3)
//   max_u         : helper used to size the shared press/repeat counter
package boton_evento_pkg;

  typedef enum logic [1:0] {
    StArm     = 2'd0,
    StIdle    = 2'd1,
    StPressed = 2'd2,
    StHeld    = 2'd3
  } boton_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/boton_evento_if.sv
// Button event bundle between the debounce stage and the mode FSM.
//   boton_db     : debounced level, 0 = pressed, idle 1
//   short_press  : 1-cycle pulse, released before the long threshold
//   long_press   : 1-cycle pulse, press reached the long threshold
//   repeat_press : 1-cycle pulse per repeat period while held
//   held         : level, high while a press is being tracked
// master = producer of boton_db / consumer of events; slave = the classifier.
interface boton_evento_if;
  logic boton_db;
  logic short_press;
  logic long_press;
  logic repeat_press;
  logic held;

  modport master (
    output boton_db,
    input  short_press,
    input  long_press,
    input  repeat_press,
    input  held
  );

  modport slave (
    input  boton_db,
    output short_press,
    output long_press,
    output repeat_press,
    output held
  );
endinterface

// File: rtl/boton_evento.sv
// Classifies debounced button presses into single-cycle short/long/repeat pulses.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-low reset (forces ARM, all outputs 0)
//   bus   : boton_evento_if.slave (boton_db in; short/long/repeat pulses and held out)
// Optional feature: define BOTON_REPEAT_EN to emit repeat_press every REPEAT_CYCLES
// while held; otherwise repeat_press is tied low and the counter idles in HELD.
module boton_evento
  import boton_evento_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 20,
  parameter int unsigned REPEAT_CYCLES = 8
) (
  input logic            clk,
  input logic            reset,
  boton_evento_if.slave  bus
);

  localparam int unsigned CntMax = max_u(LONG_CYCLES, REPEAT_CYCLES);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYCLES - 1);

  boton_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            short_q, short_d;
  logic            long_q, long_d;
  logic            repeat_q, repeat_d;
  logic            held_q, held_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StArm;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      held_q   <= held_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    held_d   = held_q;

    case (state_q)
      // A press held through reset must be released before it can count.
      StArm: begin
        if (bus.boton_db) state_d = StIdle;
      end

      StIdle: begin
        if (!bus.boton_db) begin
          state_d = StPressed;
          cnt_d   = '0;
          held_d  = 1'b1;
        end
      end

      // Release wins over a simultaneous threshold hit.
      StPressed: begin
        if (bus.boton_db) begin
          state_d = StIdle;
          cnt_d   = '0;
          short_d = 1'b1;
          held_d  = 1'b0;
        end else if (cnt_q == LongLast) begin
          state_d = StHeld;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StHeld: begin
        if (bus.boton_db) begin
          state_d = StIdle;
          cnt_d   = '0;
          held_d  = 1'b0;
        end else begin
`ifdef BOTON_REPEAT_EN
          if (cnt_q == CntW'(REPEAT_CYCLES - 1)) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          cnt_d = '0;
`endif
        end
      end

      default: begin
        state_d = StArm;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
    endcase
  end

  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.repeat_press = repeat_q;
  assign bus.held         = held_q;

endmodule

// File: tb/tb_boton_evento.sv
// Self-checking bench for boton_evento (LONG_CYCLES=20, REPEAT_CYCLES=8).
// Expected outputs packed as {short_press, long_press, repeat_press, held}.
module tb_boton_evento;

  localparam int unsigned LongC = 20;
  localparam int unsigned RepC  = 8;
`ifdef BOTON_REPEAT_EN
  localparam bit RepEn = 1'b1;
`else
  localparam bit RepEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  boton_evento_if bus ();

  boton_evento #(
    .LONG_CYCLES   (LongC),
    .REPEAT_CYCLES (RepC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       b;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[24];

  function automatic logic [3:0] outs();
    return {bus.short_press, bus.long_press, bus.repeat_press, bus.held};
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (short,long,repeat,held)", name, act, exp);
    end
  endtask

  // Apply inputs, clock one edge, sample 1 time unit after it.
  task automatic step(input logic rst_n, input logic b);
    reset = rst_n;
    bus.boton_db = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] e;
    bus.boton_db = 1'b0;

    // Reset with the button held, then keep holding: ARM must swallow it.
    step(1'b0, 1'b0);
    chk("reset_state", outs(), 4'b0000);
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0);
      chk($sformatf("arm_hold_%0d", i), outs(), 4'b0000);
    end

    //            rst   b     exp
    vecs[0]  = '{1'b1, 1'b1, 4'b0000};  // ARM -> IDLE
    vecs[1]  = '{1'b1, 1'b0, 4'b0001};  // enter PRESSED
    vecs[2]  = '{1'b1, 1'b0, 4'b0001};
    vecs[3]  = '{1'b1, 1'b0, 4'b0001};
    vecs[4]  = '{1'b1, 1'b0, 4'b0001};
    vecs[5]  = '{1'b1, 1'b0, 4'b0001};
    vecs[6]  = '{1'b1, 1'b1, 4'b1000};  // release -> short
    vecs[7]  = '{1'b1, 1'b1, 4'b0000};
    vecs[8]  = '{1'b1, 1'b0, 4'b0001};  // 1-cycle press
    vecs[9]  = '{1'b1, 1'b1, 4'b1000};
    vecs[10] = '{1'b1, 1'b1, 4'b0000};
    vecs[11] = '{1'b1, 1'b0, 4'b0001};  // press, reset mid-press
    vecs[12] = '{1'b1, 1'b0, 4'b0001};
    vecs[13] = '{1'b1, 1'b0, 4'b0001};
    vecs[14] = '{1'b0, 1'b0, 4'b0000};  // reset forces outputs low
    vecs[15] = '{1'b1, 1'b0, 4'b0000};  // ARM, still held
    vecs[16] = '{1'b1, 1'b0, 4'b0000};
    vecs[17] = '{1'b1, 1'b0, 4'b0000};
    vecs[18] = '{1'b1, 1'b1, 4'b0000};  // release -> IDLE, no pulse
    vecs[19] = '{1'b1, 1'b1, 4'b0000};
    vecs[20] = '{1'b1, 1'b0, 4'b0001};  // fresh press accepted
    vecs[21] = '{1'b1, 1'b0, 4'b0001};
    vecs[22] = '{1'b1, 1'b1, 4'b1000};
    vecs[23] = '{1'b1, 1'b1, 4'b0000};

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].b);
      chk($sformatf("vec_%0d", i), outs(), vecs[i].exp);
    end

    // Long press plus repeats: edge 0 enters PRESSED, long at edge 20,
    // repeats (if enabled) at 28, 36, 44, 52, 60.
    for (int i = 0; i <= 60; i++) begin
      step(1'b1, 1'b0);
      e = 4'b0001;
      if (i == int'(LongC)) e[2] = 1'b1;
      if (RepEn && i > int'(LongC) && ((i - int'(LongC)) % int'(RepC)) == 0) e[1] = 1'b1;
      chk($sformatf("long_hold_%0d", i), outs(), e);
    end
    step(1'b1, 1'b1);
    chk("held_release", outs(), 4'b0000);
    step(1'b1, 1'b1);
    chk("held_idle", outs(), 4'b0000);

    // Release exactly on the edge where cnt==LONG_CYCLES-1: short wins.
    for (int i = 0; i < int'(LongC); i++) begin
      step(1'b1, 1'b0);
      chk($sformatf("edge_hold_%0d", i), outs(), 4'b0001);
    end
    step(1'b1, 1'b1);
    chk("edge_release_short", outs(), 4'b1000);
    step(1'b1, 1'b1);
    chk("edge_after", outs(), 4'b0000);

    // One edge longer: long pulse, then silent release.
    for (int i = 0; i <= int'(LongC); i++) begin
      step(1'b1, 1'b0);
      chk($sformatf("min_long_%0d", i), outs(), (i == int'(LongC)) ? 4'b0101 : 4'b0001);
    end
    step(1'b1, 1'b1);
    chk("min_long_release", outs(), 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
